// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice and a carry flop process the
// operands LSB-first, with valid/ready handshakes on both the operand and result sides.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_next;
    logic             carry;
    logic [CW-1:0]    count;
    logic             s;
    logic             carry_next;

    // The single full-adder slice, always looking at bit 0 of the shifting operands.
    always_comb begin
        s          = ra[0] ^ rb[0] ^ carry;
        carry_next = (ra[0] & rb[0]) | (carry & (ra[0] ^ rb[0]));
    end

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 lands at sum[0].
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign sreg_next = s;
        end else begin : g_sum_wn
            assign sreg_next = {s, sreg[WIDTH-1:1]};
        end
    endgenerate

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            sreg  <= '0;
            carry <= 1'b0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        ra    <= a;
                        rb    <= b;
                        carry <= cin;
                        sreg  <= '0;
                        count <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    carry <= carry_next;
                    sreg  <= sreg_next;
                    ra    <= ra >> 1;
                    rb    <= rb >> 1;
                    count <= count + CW'(1);
                    if (count == LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN) || (state == DONE);
    assign sum       = sreg;
    assign cout      = carry;

endmodule
